// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings for the MEM->WB stage: load codes, register-zero address and load-wait FSM states.
package mem_wb_stage_pkg;

  localparam int unsigned LOAD_NOPE  = 0;
  localparam int unsigned INSTR_LB   = 1;
  localparam int unsigned INSTR_LH   = 2;
  localparam int unsigned INSTR_LW   = 3;
  localparam int unsigned INSTR_LD   = 4;
  localparam int unsigned INSTR_LBU  = 5;
  localparam int unsigned INSTR_LHU  = 6;
  localparam int unsigned INSTR_LWU  = 7;

  localparam int unsigned REG_ADDR_ZERO = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BUF,
    ST_DRAIN
  } wb_state_e;

endpackage

// File: rtl/mem_wb_stage_load_extract.sv
// Combinational load alignment: shifts the memory word down by the byte offset and sign/zero-extends.
module load_extract
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LCODE_W    = 3,
  parameter int unsigned OFF_W      = $clog2(DATA_WIDTH / 8)
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [OFF_W-1:0]      offset,
  input  logic [LCODE_W-1:0]    load_code,
  output logic [DATA_WIDTH-1:0] data
);

  localparam logic [LCODE_W-1:0] C_LB  = LCODE_W'(INSTR_LB);
  localparam logic [LCODE_W-1:0] C_LH  = LCODE_W'(INSTR_LH);
  localparam logic [LCODE_W-1:0] C_LW  = LCODE_W'(INSTR_LW);
  localparam logic [LCODE_W-1:0] C_LD  = LCODE_W'(INSTR_LD);
  localparam logic [LCODE_W-1:0] C_LBU = LCODE_W'(INSTR_LBU);
  localparam logic [LCODE_W-1:0] C_LHU = LCODE_W'(INSTR_LHU);
  localparam logic [LCODE_W-1:0] C_LWU = LCODE_W'(INSTR_LWU);

  logic [DATA_WIDTH-1:0] shifted;

  // At DATA_WIDTH=32 the word-sized cases degenerate to a plain pass, so LD/LWU behave as LW.
  always_comb begin
    shifted = word >> {offset, 3'b000};
    data    = shifted;
    case (load_code)
      C_LB:    data = DATA_WIDTH'($signed(shifted[7:0]));
      C_LH:    data = DATA_WIDTH'($signed(shifted[15:0]));
      C_LW:    data = DATA_WIDTH'($signed(shifted[31:0]));
      C_LD:    data = shifted;
      C_LBU:   data = DATA_WIDTH'(shifted[7:0]);
      C_LHU:   data = DATA_WIDTH'(shifted[15:0]);
      C_LWU:   data = DATA_WIDTH'(shifted[31:0]);
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline stage: holds the EX result, waits for variable-latency load responses,
// aligns/extends load data and drives the register-file write port.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned RADDR_W    = 5,
  parameter int unsigned LCODE_W    = 3,
  parameter bit          OUT_REG    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hold_n,
  input  logic                  flush_i,
  input  logic                  ex_valid_i,
  input  logic [DATA_WIDTH-1:0] data_alu_i,
  input  logic [RADDR_W-1:0]    addr_reg_wr_i,
  input  logic                  reg_wr_en_i,
  input  logic [LCODE_W-1:0]    load_code_i,
  input  logic                  mem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data_i,
  input  logic                  mem_rsp_err_i,
  output logic                  stall_o,
  output logic [RADDR_W-1:0]    addr_reg_wr_o,
  output logic [DATA_WIDTH-1:0] data_reg_wr_o,
  output logic                  reg_wr_en_o,
  output logic                  load_fault_o
);

  localparam int unsigned         OFF_W   = $clog2(DATA_WIDTH / 8);
  localparam logic [LCODE_W-1:0]  L_NOPE  = LCODE_W'(LOAD_NOPE);
  localparam logic [RADDR_W-1:0]  RD_ZERO = RADDR_W'(REG_ADDR_ZERO);

  logic                  st_valid;
  logic                  st_we;
  logic [DATA_WIDTH-1:0] st_alu;
  logic [RADDR_W-1:0]    st_rd;
  logic [LCODE_W-1:0]    st_lcode;

  logic [DATA_WIDTH-1:0] buf_data;
  logic                  buf_err;

  wb_state_e state, state_nxt;

  logic capture, st_is_load, st_clear, done, use_buf, buf_load;
  logic nl_fire, wb_fire, wb_fault, wb_we, rsp_err;
  logic [DATA_WIDTH-1:0] rsp_word, ext_data, wb_data;

  assign capture    = hold_n & ~stall_o;
  assign st_is_load = st_valid & (st_lcode != L_NOPE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_valid <= 1'b0;
      st_we    <= 1'b0;
      st_alu   <= '0;
      st_rd    <= RD_ZERO;
      st_lcode <= L_NOPE;
    end else if (capture) begin
      st_valid <= ex_valid_i & ~flush_i;
      st_we    <= reg_wr_en_i;
      st_alu   <= data_alu_i;
      st_rd    <= addr_reg_wr_i;
      st_lcode <= load_code_i;
    end else if (st_clear) begin
      st_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_data <= '0;
      buf_err  <= 1'b0;
    end else if (buf_load) begin
      buf_data <= mem_rsp_data_i;
      buf_err  <= mem_rsp_err_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // A load leaving WAIT/BUF/DRAIN clears the stage itself, since stall_o blocked the refill on that edge.
  always_comb begin
    state_nxt = state;
    stall_o   = 1'b0;
    done      = 1'b0;
    use_buf   = 1'b0;
    buf_load  = 1'b0;
    st_clear  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (st_is_load) begin
          if (flush_i) begin
            st_clear = 1'b1;
            if (!mem_rsp_valid_i) begin
              stall_o   = 1'b1;
              state_nxt = ST_DRAIN;
            end
          end else if (mem_rsp_valid_i) begin
            if (hold_n) begin
              done = 1'b1;
            end else begin
              buf_load  = 1'b1;
              state_nxt = ST_BUF;
            end
          end else begin
            stall_o   = 1'b1;
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        stall_o = 1'b1;
        if (flush_i) begin
          st_clear  = 1'b1;
          state_nxt = mem_rsp_valid_i ? ST_IDLE : ST_DRAIN;
        end else if (mem_rsp_valid_i) begin
          if (hold_n) begin
            done      = 1'b1;
            st_clear  = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            buf_load  = 1'b1;
            state_nxt = ST_BUF;
          end
        end
      end
      ST_BUF: begin
        stall_o = 1'b1;
        if (flush_i) begin
          st_clear  = 1'b1;
          state_nxt = ST_IDLE;
        end else if (hold_n) begin
          done      = 1'b1;
          use_buf   = 1'b1;
          st_clear  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        stall_o = 1'b1;
        if (mem_rsp_valid_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign rsp_word = use_buf ? buf_data : mem_rsp_data_i;
  assign rsp_err  = use_buf ? buf_err  : mem_rsp_err_i;

  load_extract #(
    .DATA_WIDTH (DATA_WIDTH),
    .LCODE_W    (LCODE_W),
    .OFF_W      (OFF_W)
  ) u_load_extract (
    .word      (rsp_word),
    .offset    (st_alu[OFF_W-1:0]),
    .load_code (st_lcode),
    .data      (ext_data)
  );

  assign nl_fire  = (state == ST_IDLE) & st_valid & ~st_is_load & ~flush_i;
  assign wb_fire  = nl_fire | done;
  assign wb_fault = done & rsp_err;
  assign wb_we    = wb_fire & st_we & (st_rd != RD_ZERO) & ~wb_fault;
  assign wb_data  = done ? ext_data : st_alu;

  if (OUT_REG) begin : g_out_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        reg_wr_en_o   <= 1'b0;
        load_fault_o  <= 1'b0;
        addr_reg_wr_o <= RD_ZERO;
        data_reg_wr_o <= '0;
      end else if (hold_n) begin
        reg_wr_en_o   <= wb_we;
        load_fault_o  <= wb_fault;
        addr_reg_wr_o <= st_rd;
        data_reg_wr_o <= wb_data;
      end
    end
  end else begin : g_out_comb
    always_comb begin
      reg_wr_en_o   = wb_we;
      load_fault_o  = wb_fault;
      addr_reg_wr_o = st_rd;
      data_reg_wr_o = wb_data;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage (64-bit, registered writeback) with a queue-based writeback scoreboard.
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  localparam logic [2:0] NOPE = 3'(LOAD_NOPE);
  localparam logic [2:0] LB   = 3'(INSTR_LB);
  localparam logic [2:0] LH   = 3'(INSTR_LH);
  localparam logic [2:0] LW   = 3'(INSTR_LW);
  localparam logic [2:0] LD   = 3'(INSTR_LD);
  localparam logic [2:0] LBU  = 3'(INSTR_LBU);
  localparam logic [2:0] LHU  = 3'(INSTR_LHU);
  localparam logic [2:0] LWU  = 3'(INSTR_LWU);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hold_n = 1'b1;
  logic        flush_i = 1'b0;
  logic        ex_valid_i = 1'b0;
  logic [63:0] data_alu_i = '0;
  logic [4:0]  addr_reg_wr_i = '0;
  logic        reg_wr_en_i = 1'b0;
  logic [2:0]  load_code_i = '0;
  logic        mem_rsp_valid_i = 1'b0;
  logic [63:0] mem_rsp_data_i = '0;
  logic        mem_rsp_err_i = 1'b0;
  logic        stall_o;
  logic [4:0]  addr_reg_wr_o;
  logic [63:0] data_reg_wr_o;
  logic        reg_wr_en_o;
  logic        load_fault_o;

  mem_wb_stage #(
    .DATA_WIDTH (64),
    .RADDR_W    (5),
    .LCODE_W    (3),
    .OUT_REG    (1'b1)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .hold_n          (hold_n),
    .flush_i         (flush_i),
    .ex_valid_i      (ex_valid_i),
    .data_alu_i      (data_alu_i),
    .addr_reg_wr_i   (addr_reg_wr_i),
    .reg_wr_en_i     (reg_wr_en_i),
    .load_code_i     (load_code_i),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_data_i  (mem_rsp_data_i),
    .mem_rsp_err_i   (mem_rsp_err_i),
    .stall_o         (stall_o),
    .addr_reg_wr_o   (addr_reg_wr_o),
    .data_reg_wr_o   (data_reg_wr_o),
    .reg_wr_en_o     (reg_wr_en_o),
    .load_fault_o    (load_fault_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic        fault;
    logic [4:0]  rd;
    logic [63:0] data;
  } exp_t;

  typedef struct {
    logic [2:0]  lc;
    logic [63:0] alu;
    logic [63:0] word;
    logic [63:0] exp;
  } ld_vec_t;

  exp_t    q[$];
  exp_t    e;
  ld_vec_t vecs[$];

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic        chk_stall = 1'b0;
  logic        exp_stall = 1'b0;
  logic        end_req = 1'b0;
  logic        ok;

  // Monitor: owns all comparisons and counters.
  always @(negedge clk) begin
    if (!rst_n) begin
      checks = checks + 1;
      if (stall_o !== 1'b0 || reg_wr_en_o !== 1'b0 || load_fault_o !== 1'b0 ||
          addr_reg_wr_o !== 5'd0 || data_reg_wr_o !== 64'd0) begin
        errors = errors + 1;
        $display("FAIL reset_outputs: stall=%b en=%b fault=%b addr=%0d data=%h, required all 0",
                 stall_o, reg_wr_en_o, load_fault_o, addr_reg_wr_o, data_reg_wr_o);
      end
    end else begin
      if (chk_stall) begin
        checks = checks + 1;
        if (stall_o !== exp_stall) begin
          errors = errors + 1;
          $display("FAIL stall cyc=%0d: got %b required %b", cyc, stall_o, exp_stall);
        end
      end
      if (reg_wr_en_o === 1'b1 || load_fault_o === 1'b1) begin
        checks = checks + 1;
        if (q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL unexpected_wb cyc=%0d: en=%b fault=%b addr=%0d data=%h, required no writeback",
                   cyc, reg_wr_en_o, load_fault_o, addr_reg_wr_o, data_reg_wr_o);
        end else begin
          e = q.pop_front();
          if (e.fault)
            ok = (load_fault_o === 1'b1) && (reg_wr_en_o === 1'b0) && (cyc == e.cyc);
          else
            ok = (reg_wr_en_o === 1'b1) && (load_fault_o === 1'b0) && (cyc == e.cyc) &&
                 (addr_reg_wr_o === e.rd) && (data_reg_wr_o === e.data);
          if (!ok) begin
            errors = errors + 1;
            $display("FAIL wb: got cyc=%0d en=%b fault=%b rd=%0d data=%h required cyc=%0d fault=%b rd=%0d data=%h",
                     cyc, reg_wr_en_o, load_fault_o, addr_reg_wr_o, data_reg_wr_o,
                     e.cyc, e.fault, e.rd, e.data);
          end
        end
      end
    end
    if (end_req) begin
      checks = checks + 1;
      if (q.size() != 0) begin
        errors = errors + 1;
        $display("FAIL missing_wb: %0d outstanding, required 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic s);
    exp_stall = s;
    chk_stall = 1'b1;
    tick();
    chk_stall = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic we, input logic [2:0] lc,
                       input logic [63:0] alu);
    ex_valid_i    = 1'b1;
    addr_reg_wr_i = rd;
    reg_wr_en_i   = we;
    load_code_i   = lc;
    data_alu_i    = alu;
    tick();
    ex_valid_i  = 1'b0;
    reg_wr_en_i = 1'b0;
    load_code_i = NOPE;
  endtask

  task automatic rsp_set(input logic [63:0] w, input logic err);
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = w;
    mem_rsp_err_i   = err;
  endtask

  task automatic rsp_clr();
    mem_rsp_valid_i = 1'b0;
    mem_rsp_err_i   = 1'b0;
  endtask

  task automatic expect_wb(input int unsigned at, input logic [4:0] rd, input logic [63:0] d,
                           input logic f);
    q.push_back(exp_t'{at, f, rd, d});
  endtask

  initial begin
    vecs.push_back(ld_vec_t'{LHU, 64'h0000_0000_1000_0002, 64'h0000_0000_8001_0000, 64'h0000_0000_0000_8001});
    vecs.push_back(ld_vec_t'{LH,  64'h0000_0000_1000_0006, 64'h8765_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8765});
    vecs.push_back(ld_vec_t'{LWU, 64'h0000_0000_1000_0004, 64'hF000_0001_0000_0000, 64'h0000_0000_F000_0001});
    vecs.push_back(ld_vec_t'{LW,  64'h0000_0000_1000_0004, 64'hF000_0001_0000_0000, 64'hFFFF_FFFF_F000_0001});
    vecs.push_back(ld_vec_t'{LBU, 64'h0000_0000_1000_0007, 64'hAB00_0000_0000_0000, 64'h0000_0000_0000_00AB});
    vecs.push_back(ld_vec_t'{LD,  64'h0000_0000_1000_0000, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF});

    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // ADD: write one cycle after capture; rd=0 and we=0 never strobe
    issue(5'd5, 1'b1, NOPE, 64'h1234);
    expect_wb(cyc + 1, 5'd5, 64'h1234, 1'b0);
    step(1'b0);
    step(1'b0);
    issue(5'd0, 1'b1, NOPE, 64'hFFFF);
    step(1'b0);
    issue(5'd6, 1'b0, NOPE, 64'h77);
    step(1'b0);
    step(1'b0);

    // LB, response in third stall cycle
    issue(5'd7, 1'b1, LB, 64'h0000_0000_1000_0003);
    expect_wb(cyc + 3, 5'd7, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    step(1'b1);
    step(1'b1);
    rsp_set(64'h0000_0000_8000_0000, 1'b0);
    step(1'b1);
    rsp_clr();
    step(1'b0);

    // Same-cycle responses: no stall, extraction table
    foreach (vecs[i]) begin
      issue(5'(9 + i), 1'b1, vecs[i].lc, vecs[i].alu);
      expect_wb(cyc + 1, 5'(9 + i), vecs[i].exp, 1'b0);
      rsp_set(vecs[i].word, 1'b0);
      step(1'b0);
      rsp_clr();
      step(1'b0);
    end

    // LW flushed in WAIT, response drained two cycles later
    issue(5'd20, 1'b1, LW, 64'h0000_0000_2000_0004);
    step(1'b1);
    flush_i = 1'b1;
    step(1'b1);
    flush_i = 1'b0;
    step(1'b1);
    rsp_set(64'h1111_2222_3333_4444, 1'b0);
    step(1'b1);
    rsp_clr();
    step(1'b0);

    // Flush and response together in WAIT: dropped, straight to IDLE
    issue(5'd21, 1'b1, LW, 64'h0000_0000_2000_0000);
    step(1'b1);
    flush_i = 1'b1;
    rsp_set(64'h5555_6666_7777_8888, 1'b0);
    step(1'b1);
    flush_i = 1'b0;
    rsp_clr();
    step(1'b0);
    issue(5'd22, 1'b1, NOPE, 64'hABCD);
    expect_wb(cyc + 1, 5'd22, 64'hABCD, 1'b0);
    step(1'b0);
    step(1'b0);

    // LD response during a 4-cycle hold: buffered, written after release
    issue(5'd12, 1'b1, LD, 64'h0000_0000_3000_0000);
    expect_wb(cyc + 6, 5'd12, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
    step(1'b1);
    hold_n = 1'b0;
    rsp_set(64'hDEAD_BEEF_CAFE_F00D, 1'b0);
    step(1'b1);
    rsp_clr();
    step(1'b1);
    step(1'b1);
    step(1'b1);
    hold_n = 1'b1;
    step(1'b1);
    step(1'b0);

    // Faulting LB to rd=0
    issue(5'd0, 1'b1, LB, 64'h0000_0000_4000_0001);
    expect_wb(cyc + 2, 5'd0, 64'd0, 1'b1);
    step(1'b1);
    rsp_set(64'h0000_0000_0000_FF00, 1'b1);
    step(1'b1);
    rsp_clr();
    step(1'b0);
    step(1'b0);

    // Reset in the middle of WAIT, then normal operation resumes
    issue(5'd3, 1'b1, LW, 64'h0000_0000_5000_0000);
    step(1'b1);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    step(1'b0);
    issue(5'd4, 1'b1, NOPE, 64'h55);
    expect_wb(cyc + 1, 5'd4, 64'h55, 1'b0);
    step(1'b0);
    step(1'b0);

    end_req = 1'b1;
    tick();
  end

endmodule
